// File: rtl/cpu_pkg.sv
// Shared CPU front-end defaults and types.
// Fetch widths, reset vector and fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int INSTR_W_DEF  = 19;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between fetch and decode.
// Head is read straight from registered storage.
module fetch_fifo #(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties without touching data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch unit: PC, fetch FSM and 2-deep buffer.
// Redirect flushes the buffer and reloads the PC ahead of all else.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy
);

  localparam int EW = INSTR_W + ADDR_W;

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic [EW-1:0]     head;
  logic              push;
  logic              pop;
  logic              room;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head[EW-1:ADDR_W];
  assign out_pc    = head[ADDR_W-1:0];
  assign busy      = (state == S_FETCH);

  assign pop  = out_valid && out_ready && !redirect_valid;
  assign room = (count != 2'd2) || pop;
  assign push = (state == S_FETCH) && !halt &&
                !redirect_valid && room;

  // Next-state logic; a redirect freezes the state for that cycle.
  always_comb begin
    state_nx = state;
    if (!redirect_valid) begin
      unique case (state)
        S_IDLE:   if (start) state_nx = S_FETCH;
        S_FETCH:  if (halt) state_nx = S_HALTED;
        S_HALTED: if (!halt) state_nx = S_FETCH;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // PC: reload on redirect, advance on every push, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= ADDR_W'(RESET_PC);
    else if (redirect_valid) pc <= redirect_target;
    else if (push)           pc <= pc + 1'b1;
  end

  fetch_fifo #(
    .W (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({imem_instr, pc}),
    .count (count),
    .head  (head)
  );

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 19, the instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, as fixed below.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins fetching from IDLE.
REQ-008 halt  input  1  level; stops new fetches while high.
REQ-009 imem_addr  output  ADDR_W  address to instruction memory.
REQ-010 imem_instr  input  INSTR_W  combinational memory data for imem_addr, same cycle.
REQ-011 redirect_valid  input  1  jump/branch taken; one-cycle pulse.
REQ-012 redirect_target  input  ADDR_W  new PC, sampled when redirect_valid is high.
REQ-013 out_valid  output  1  out_instr/out_pc hold a valid instruction.
REQ-014 out_ready  input  1  decode stage accepts the instruction.
REQ-015 out_instr  output  INSTR_W  fetched instruction at the head of the buffer.
REQ-016 out_pc  output  ADDR_W  address of out_instr.
REQ-017 busy  output  1  high in FETCH state.

Function
REQ-018 States SHALL be IDLE, FETCH and HALTED.
- IDLE->FETCH on start.
- FETCH->HALTED when halt is high.
- HALTED->FETCH when halt is low.
REQ-019 imem_addr SHALL equal the PC register at all times.
REQ-020 Push rule: in FETCH, a push of {imem_instr, pc} into a 2-entry FIFO occurs when count<2, or when count==2 and a pop happens in the same cycle; the PC then increments.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W; 4095 is followed by 0.
REQ-022 Pop SHALL occur when out_valid && out_ready.
REQ-023 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL be the FIFO head, registered with no combinational path from imem_instr.
REQ-024 With a full FIFO and no pop, the PC and FIFO SHALL hold, and imem_addr SHALL stay stable.
REQ-025 Redirect SHALL take priority over push, pop, halt and start:
- flush the FIFO (count=0), discarding any push or pop that cycle;
- load the PC with redirect_target;
- out_valid SHALL be 0 in the following cycle.
REQ-026 Redirect in IDLE or HALTED SHALL load the PC and flush the FIFO without changing state.
REQ-027 In HALTED and IDLE, no push SHALL occur; pops continue, so the FIFO drains.
REQ-028 Latency: with start at edge N and out_ready high, out_valid=1 with out_pc=RESET_PC after edge N+2; throughput is one instruction per cycle.
REQ-029 Out-of-state events: start outside IDLE SHALL be ignored; halt and start in the same cycle in IDLE SHALL go to FETCH, then to HALTED one cycle later.

Reset
REQ-030 On rst:
- PC=RESET_PC, state=IDLE, FIFO count=0;
- out_valid=0, out_instr=0, out_pc=0, busy=0;
- imem_addr=RESET_PC.
REQ-031 Reset asserted mid-operation SHALL abort immediately; the FIFO contents are lost and no out_valid glitch occurs after release.

Structure
REQ-032 Package cpu_pkg SHALL hold ADDR_W, INSTR_W, RESET_PC defaults and the fetch state enum type.
REQ-033 The 2-entry FIFO SHALL be the sub-module fetch_fifo (push, pop, flush, count, head), with the same async reset.

Verification
REQ-034 Reset, start, out_ready=1, memory word k = k: out_pc sequence 0,1,2,3 on consecutive cycles starting two cycles after start.
REQ-035 out_ready=0 for 5 cycles after the first valid: count saturates at 2, imem_addr holds at 2, and output resumes 0,1,2 with no loss or duplication.
REQ-036 redirect_valid with target 15 while the FIFO is full: next cycle out_valid=0, the cycle after that out_pc=15; prior entries never appear.
REQ-037 redirect to 4094: out_pc 4094, 4095, 0, 1.
REQ-038 halt high for 4 cycles: no imem_addr advance, FIFO drains to empty, busy=0; after halt falls, fetch resumes at the next address.
REQ-039 rst pulsed mid-stream with count=2: out_valid=0 immediately; a later start restarts at RESET_PC.
